// File: rtl/rcv_dqfifo_rdptr_mstep.sv
// Read-side pointer logic for a dual-clock FIFO with multi-entry pops.
// Exported Gray pointer trails the binary pointer one step per cycle so it never moves more than one bit.
module rcv_dqfifo_rdptr_mstep #(
  parameter int ADDR_W    = 8,
  parameter int STEP_W    = 3,
  parameter int AEMPTY_TH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic [ADDR_W:0]   wr_gptr_sync,
  input  logic              rd_en,
  input  logic [STEP_W-1:0] rd_step,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [ADDR_W:0]   rd_gptr,
  output logic [ADDR_W:0]   level,
  output logic              empty,
  output logic              aempty,
  output logic              underflow,
  output logic              sync_lag
);

  localparam int PW       = ADDR_W + 1;
  localparam int MAX_STEP = 2 ** (STEP_W - 1);

  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [PW-1:0] rd_bin;
  logic [PW-1:0] wr_bin_q;
  logic [PW-1:0] exp_bin;
  logic [PW-1:0] exp_nxt;
  logic [PW-1:0] wr_bin_now;
  logic [31:0]   step32;
  logic [31:0]   level32;
  logic          pop_ok;

  assign wr_bin_now = gray2bin(wr_gptr_sync);
  assign level      = wr_bin_q - rd_bin;
  assign empty      = (level == '0);
  assign level32    = 32'(level);
  assign aempty     = (level32 <= 32'(AEMPTY_TH));
  assign rd_addr    = rd_bin[ADDR_W-1:0];
  assign sync_lag   = (exp_bin != rd_bin);

  assign step32 = 32'(rd_step);
  assign pop_ok = (step32 != 32'd0) && (step32 <= 32'(MAX_STEP)) && (step32 <= level32);

  // export pointer chases the current rd_bin one increment at a time
  assign exp_nxt = (exp_bin != rd_bin) ? exp_bin + PW'(1) : exp_bin;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_bin    <= '0;
      wr_bin_q  <= '0;
      exp_bin   <= '0;
      rd_gptr   <= '0;
      underflow <= 1'b0;
    end else begin
      wr_bin_q  <= wr_bin_now;
      exp_bin   <= exp_nxt;
      rd_gptr   <= exp_nxt ^ (exp_nxt >> 1);
      underflow <= 1'b0;
      if (flush) begin
        rd_bin <= wr_bin_now;
      end else if (rd_en) begin
        if (pop_ok) begin
          rd_bin <= rd_bin + PW'(rd_step);
        end else begin
          underflow <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_rcv_dqfifo_rdptr_mstep.sv
// Randomized and directed bench for rcv_dqfifo_rdptr_mstep (ADDR_W=4) against an arithmetic pointer model.
module tb_rcv_dqfifo_rdptr_mstep;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic [4:0] wr_gptr_sync;
  logic       rd_en;
  logic [2:0] rd_step;
  logic [3:0] rd_addr;
  logic [4:0] rd_gptr;
  logic [4:0] level;
  logic       empty, aempty, underflow, sync_lag;

  int vectors = 0;
  int errors  = 0;

  // model state: pointers as plain integers modulo 32
  int w_bin;
  int m_rd, m_wrq, m_exp, m_uf;

  rcv_dqfifo_rdptr_mstep #(.ADDR_W(4), .STEP_W(3), .AEMPTY_TH(2)) dut (
    .clk(clk), .rst(rst), .flush(flush), .wr_gptr_sync(wr_gptr_sync),
    .rd_en(rd_en), .rd_step(rd_step), .rd_addr(rd_addr), .rd_gptr(rd_gptr),
    .level(level), .empty(empty), .aempty(aempty), .underflow(underflow),
    .sync_lag(sync_lag)
  );

  always #5 clk = ~clk;

  function automatic int gray(input int b);
    return (b ^ (b >> 1)) & 31;
  endfunction

  task automatic chk(input string name, input int act, input int req);
    vectors++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_rd = 0; m_wrq = 0; m_exp = 0; m_uf = 0;
  endtask

  task automatic check_model();
    int lvl;
    lvl = (m_wrq - m_rd) & 31;
    chk("rd_addr",   int'(rd_addr),   m_rd & 15);
    chk("level",     int'(level),     lvl);
    chk("empty",     int'(empty),     (lvl == 0) ? 1 : 0);
    chk("aempty",    int'(aempty),    (lvl <= 2) ? 1 : 0);
    chk("underflow", int'(underflow), m_uf);
    chk("sync_lag",  int'(sync_lag),  (m_exp != m_rd) ? 1 : 0);
    chk("rd_gptr",   int'(rd_gptr),   gray(m_exp));
  endtask

  // Call at a negedge: drive inputs, apply one rising edge to the model, compare at next negedge.
  task automatic step(input bit f, input bit en, input int stp);
    int lvl;
    flush = f; rd_en = en; rd_step = 3'(stp);
    wr_gptr_sync = 5'(gray(w_bin));
    @(posedge clk);
    lvl  = (m_wrq - m_rd) & 31;
    m_uf = 0;
    if (m_exp != m_rd) m_exp = (m_exp + 1) & 31;
    if (f) m_rd = w_bin & 31;
    else if (en) begin
      if (stp >= 1 && stp <= 4 && stp <= lvl) m_rd = (m_rd + stp) & 31;
      else m_uf = 1;
    end
    m_wrq = w_bin & 31;
    @(negedge clk);
    check_model();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    model_reset();
    w_bin = 0;
    flush = 1'b0; rd_en = 1'b0; rd_step = 3'd0; wr_gptr_sync = 5'd0;
    @(posedge clk);
    #3 rst = 1'b0;
    @(negedge clk);
    check_model();
  endtask

  initial begin
    int prev_g;
    rst = 1'b1; flush = 1'b0; rd_en = 1'b0; rd_step = 3'd0; wr_gptr_sync = 5'd0;
    w_bin = 0;
    model_reset();
    #12;
    chk("rst_level", int'(level), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_aempty", int'(aempty), 1);
    chk("rst_sync_lag", int'(sync_lag), 0);
    #6 rst = 1'b0;
    @(negedge clk);
    check_model();

    // write pointer to 6, then one multi-step pop
    w_bin = 6;
    idle(1);
    chk("d30_level", int'(level), 6);
    chk("d30_empty", int'(empty), 0);
    chk("d30_aempty", int'(aempty), 0);
    step(1'b0, 1'b1, 4);
    chk("d30_rd_addr", int'(rd_addr), 4);
    chk("d30_level2", int'(level), 2);
    chk("d30_aempty2", int'(aempty), 1);
    idle(1); chk("d30_g1", int'(rd_gptr), 1);
    idle(1); chk("d30_g2", int'(rd_gptr), 3);
    idle(1); chk("d30_g3", int'(rd_gptr), 2);
    idle(1); chk("d30_g4", int'(rd_gptr), 6);
    chk("d30_lag_done", int'(sync_lag), 0);

    // pop larger than level is rejected
    w_bin = 7;
    idle(1);
    chk("d31_level", int'(level), 3);
    step(1'b0, 1'b1, 4);
    chk("d31_uf", int'(underflow), 1);
    chk("d31_rd_addr", int'(rd_addr), 4);
    chk("d31_level2", int'(level), 3);
    idle(1);
    chk("d31_uf_pulse", int'(underflow), 0);

    // illegal step values
    step(1'b0, 1'b1, 0);
    chk("d32_uf0", int'(underflow), 1);
    chk("d32_addr0", int'(rd_addr), 4);
    step(1'b0, 1'b1, 5);
    chk("d32_uf5", int'(underflow), 1);
    chk("d32_addr5", int'(rd_addr), 4);

    // flush with simultaneous pop request
    do_reset();
    w_bin = 2;
    idle(1);
    step(1'b0, 1'b1, 2);
    idle(3);
    w_bin = 13;
    prev_g = int'(rd_gptr);
    step(1'b1, 1'b1, 1);
    chk("d33_rd_addr", int'(rd_addr), 13);
    chk("d33_level", int'(level), 0);
    chk("d33_empty", int'(empty), 1);
    chk("d33_uf", int'(underflow), 0);
    for (int i = 0; i < 12; i++) begin
      chk("d33_onebit", $countones(5'(prev_g) ^ rd_gptr) <= 1 ? 1 : 0, 1);
      prev_g = int'(rd_gptr);
      idle(1);
    end
    chk("d33_g13", int'(rd_gptr), gray(13));

    // wrap: rd_bin=30, wr=2 (mod 32)
    do_reset();
    w_bin = 16;
    idle(1);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 4);
    w_bin = 30;
    idle(1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 4);
    step(1'b0, 1'b1, 2);
    w_bin = 34 & 31;
    idle(1);
    chk("d34_level", int'(level), 4);
    step(1'b0, 1'b1, 3);
    chk("d34_rd_addr", int'(rd_addr), 1);
    chk("d34_level2", int'(level), 1);

    // asynchronous reset in the middle of a pop
    @(negedge clk);
    flush = 1'b0; rd_en = 1'b1; rd_step = 3'd1;
    #2 rst = 1'b1;
    #1;
    chk("d35_rd_addr", int'(rd_addr), 0);
    chk("d35_level", int'(level), 0);
    chk("d35_empty", int'(empty), 1);
    chk("d35_aempty", int'(aempty), 1);
    chk("d35_uf", int'(underflow), 0);
    chk("d35_gptr", int'(rd_gptr), 0);
    chk("d35_lag", int'(sync_lag), 0);
    model_reset();
    w_bin = 0;
    @(posedge clk);
    #3 rst = 1'b0;
    @(negedge clk);
    idle(2);
    chk("d35_uf_after", int'(underflow), 0);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      int room, inc;
      bit f, en;
      room = 16 - ((w_bin - m_rd) & 31);
      inc  = (room > 3) ? 3 : room;
      w_bin = (w_bin + $urandom_range(inc, 0)) & 31;
      f  = ($urandom_range(99, 0) < 3);
      en = $urandom_range(1, 0) == 1;
      step(f, en, $urandom_range(7, 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
